// File: rtl/address_register_bank.sv
// Parametrised address register bank: NREG address registers with two
// combinational read ports and a stack engine on register SP_IDX
// (pre-decrement push, post-increment pop) with sticky limit flags.
module address_register_bank #(
    parameter int WIDTH       = 16,
    parameter int NREG        = 4,
    parameter int SEL_W       = $clog2(NREG),
    parameter int STEP        = 1,
    parameter int SP_IDX      = NREG - 1,
    parameter int SP_LIMIT_LO = 0,
    parameter int SP_LIMIT_HI = 2**WIDTH - 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [NREG-1:0]  RegSel,
    input  logic [2:0]       FunSel,
    input  logic [SEL_W-1:0] OutCSel,
    input  logic [SEL_W-1:0] OutDSel,
    input  logic [1:0]       StackOp,
    input  logic             ClrFlags,
    output logic [WIDTH-1:0] OutC,
    output logic [WIDTH-1:0] OutD,
    output logic [WIDTH-1:0] OutS,
    output logic             Overflow,
    output logic             Underflow
);

    localparam int               HALF   = WIDTH / 2;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] SP_RST = WIDTH'(SP_LIMIT_HI);
    // Limit arithmetic is done one bit wider so it never wraps.
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   LO_X   = (WIDTH+1)'(SP_LIMIT_LO);
    localparam logic [WIDTH:0]   HI_X   = (WIDTH+1)'(SP_LIMIT_HI);

    typedef enum logic [2:0] {
        FUN_DEC   = 3'b000,
        FUN_INC   = 3'b001,
        FUN_LOAD  = 3'b010,
        FUN_CLR   = 3'b011,
        FUN_LDLO  = 3'b100,
        FUN_LDHI  = 3'b101,
        FUN_HOLD0 = 3'b110,
        FUN_HOLD1 = 3'b111
    } fun_e;

    typedef enum logic [1:0] {
        STK_NONE = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10,
        STK_RSVD = 2'b11
    } stk_e;

    logic [WIDTH-1:0] regs_r      [NREG];
    logic [WIDTH-1:0] regs_next_s [NREG];
    logic             ovf_r;
    logic             unf_r;
    logic             ovf_next_s;
    logic             unf_next_s;
    logic [WIDTH-1:0] sp_s;
    logic [WIDTH:0]   sp_x_s;
    logic [WIDTH-1:0] sp_next_s;
    logic [WIDTH-1:0] outs_s;
    logic             stack_own_s;
    logic             push_blk_s;
    logic             pop_blk_s;

    // Result of one FunSel operation applied to a register value.
    function automatic logic [WIDTH-1:0] fun_apply(
        input logic [WIDTH-1:0] cur,
        input logic [2:0]       fs,
        input logic [WIDTH-1:0] din
    );
        logic [WIDTH-1:0] res;
        case (fs)
            FUN_DEC:  res = cur - STEP_W;
            FUN_INC:  res = cur + STEP_W;
            FUN_LOAD: res = din;
            FUN_CLR:  res = {WIDTH{1'b0}};
            FUN_LDLO: res = {{(WIDTH-HALF){1'b0}}, din[HALF-1:0]};
            FUN_LDHI: res = {din[HALF-1:0], cur[HALF-1:0]};
            default:  res = cur;
        endcase
        return res;
    endfunction

    assign sp_s      = regs_r[SP_IDX];
    assign sp_x_s    = {1'b0, sp_s};
    assign OutS      = outs_s;
    assign Overflow  = ovf_r;
    assign Underflow = unf_r;

    // Stack engine: limit checks, next SP and the stack memory address.
    always_comb begin
        stack_own_s = 1'b0;
        push_blk_s  = 1'b0;
        pop_blk_s   = 1'b0;
        sp_next_s   = sp_s;
        outs_s      = sp_s;
        case (StackOp)
            STK_PUSH: begin
                stack_own_s = 1'b1;
                if (sp_x_s < (LO_X + STEP_X)) begin
                    push_blk_s = 1'b1;
                end else begin
                    sp_next_s = sp_s - STEP_W;
                    outs_s    = sp_s - STEP_W;
                end
            end
            STK_POP: begin
                stack_own_s = 1'b1;
                if ((sp_x_s + STEP_X) > HI_X) begin
                    pop_blk_s = 1'b1;
                end else begin
                    sp_next_s = sp_s + STEP_W;
                end
            end
            default: begin
                stack_own_s = 1'b0;
            end
        endcase
    end

    // Next register values; an active stack op owns SP over FunSel.
    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            if ((k == SP_IDX) && stack_own_s) begin
                regs_next_s[k] = sp_next_s;
            end else if (!RegSel[k]) begin
                regs_next_s[k] = fun_apply(regs_r[k], FunSel, I);
            end else begin
                regs_next_s[k] = regs_r[k];
            end
        end
    end

    // Sticky flags: a new violation beats a simultaneous clear.
    always_comb begin
        ovf_next_s = push_blk_s ? 1'b1 : (ClrFlags ? 1'b0 : ovf_r);
        unf_next_s = pop_blk_s  ? 1'b1 : (ClrFlags ? 1'b0 : unf_r);
    end

    // Read ports: out-of-range selects fall through to zero.
    always_comb begin
        OutC = {WIDTH{1'b0}};
        OutD = {WIDTH{1'b0}};
        for (int k = 0; k < NREG; k++) begin
            OutC = OutC | ((OutCSel == SEL_W'(k)) ? regs_r[k] : {WIDTH{1'b0}});
            OutD = OutD | ((OutDSel == SEL_W'(k)) ? regs_r[k] : {WIDTH{1'b0}});
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int k = 0; k < NREG; k++) begin
                regs_r[k] <= (k == SP_IDX) ? SP_RST : {WIDTH{1'b0}};
            end
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            for (int k = 0; k < NREG; k++) begin
                regs_r[k] <= regs_next_s[k];
            end
            ovf_r <= ovf_next_s;
            unf_r <= unf_next_s;
        end
    end

endmodule

// File: tb/tb_address_register_bank.sv
// Scoreboard bench for address_register_bank: stimulus pushes expected
// outputs from an arithmetic reference model, a negedge monitor compares.
`timescale 1ns/1ps
module tb_address_register_bank;

    localparam int LO   = 0;
    localparam int HI   = 65535;
    localparam int STEP = 1;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] I;
    logic [3:0]  RegSel;
    logic [2:0]  FunSel;
    logic [1:0]  OutCSel, OutDSel;
    logic [1:0]  StackOp;
    logic        ClrFlags;
    logic [15:0] OutC, OutD, OutS;
    logic        Overflow, Underflow;

    logic [2:0]  RegSel3 = 3'b111;
    logic [1:0]  StackOp3 = 2'b00;
    logic [1:0]  OutCSel3 = 2'd3;
    logic [1:0]  OutDSel3 = 2'd0;
    logic [15:0] OutC3, OutD3, OutS3;
    logic        Overflow3, Underflow3;

    always #5 Clock = ~Clock;

    address_register_bank dut (
        .Clock(Clock), .Reset(Reset), .I(I), .RegSel(RegSel), .FunSel(FunSel),
        .OutCSel(OutCSel), .OutDSel(OutDSel), .StackOp(StackOp),
        .ClrFlags(ClrFlags), .OutC(OutC), .OutD(OutD), .OutS(OutS),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    address_register_bank #(.NREG(3)) dut3 (
        .Clock(Clock), .Reset(Reset), .I(I), .RegSel(RegSel3), .FunSel(FunSel),
        .OutCSel(OutCSel3), .OutDSel(OutDSel3), .StackOp(StackOp3),
        .ClrFlags(1'b0), .OutC(OutC3), .OutD(OutD3), .OutS(OutS3),
        .Overflow(Overflow3), .Underflow(Underflow3)
    );

    typedef struct {
        logic [15:0] c, d, s, c3, d3;
        logic        ov, un;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   m[4];
    int   m3[3];
    int   mov, mun;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic int fun(input int v, input logic [2:0] fs, input int din);
        case (fs)
            3'd0:    return (v - STEP + 65536) % 65536;
            3'd1:    return (v + STEP) % 65536;
            3'd2:    return din;
            3'd3:    return 0;
            3'd4:    return din % 256;
            3'd5:    return (din % 256) * 256 + (v % 256);
            default: return v;
        endcase
    endfunction

    task automatic model_reset();
        m   = '{0, 0, 0, HI};
        m3  = '{0, 0, HI};
        mov = 0;
        mun = 0;
    endtask

    // One cycle: drive inputs, queue expected outputs, advance the model.
    task automatic cyc(input logic rst, input int din, input logic [3:0] rs,
                       input logic [2:0] fs, input int cs, input int ds,
                       input int sop, input logic clr,
                       input int wc = -1, input int wd = -1, input int ws = -1);
        exp_t e;
        int sp, outs, nsp, ds3;
        bit pb, ub;
        Reset    = rst;
        I        = 16'(din);
        RegSel   = rs;
        FunSel   = fs;
        OutCSel  = 2'(cs);
        OutDSel  = 2'(ds);
        StackOp  = 2'(sop);
        ClrFlags = clr;
        ds3      = $urandom_range(0, 3);
        OutDSel3 = 2'(ds3);
        sp = m[3]; outs = sp; nsp = sp; pb = 0; ub = 0;
        if (sop == 1) begin
            if (sp < LO + STEP) pb = 1;
            else begin outs = sp - STEP; nsp = outs; end
        end else if (sop == 2) begin
            if (sp + STEP > HI) ub = 1;
            else nsp = sp + STEP;
        end
        e.c  = 16'((wc >= 0) ? wc : m[cs]);
        e.d  = 16'((wd >= 0) ? wd : m[ds]);
        e.s  = 16'((ws >= 0) ? ws : outs);
        e.ov = (mov != 0);
        e.un = (mun != 0);
        e.c3 = 16'h0000;
        e.d3 = 16'((ds3 < 3) ? m3[ds3] : 0);
        q.push_back(e);
        if (!rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (k == 3 && (sop == 1 || sop == 2)) m[k] = nsp;
                else if (!rs[k]) m[k] = fun(m[k], fs, din);
            end
            mov = pb ? 1 : (clr ? 0 : mov);
            mun = ub ? 1 : (clr ? 0 : mun);
        end
        @(posedge Clock);
        #1;
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    always @(negedge Clock) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("OutC", OutC, mon_e.c);
            chk("OutD", OutD, mon_e.d);
            chk("OutS", OutS, mon_e.s);
            chk("Overflow", {15'd0, Overflow}, {15'd0, mon_e.ov});
            chk("Underflow", {15'd0, Underflow}, {15'd0, mon_e.un});
            chk("OutC_nreg3_sel3", OutC3, mon_e.c3);
            chk("OutD_nreg3", OutD3, mon_e.d3);
        end
    end

    initial begin
        int waited;
        Reset = 1'b0; I = 16'h0; RegSel = 4'hF; FunSel = 3'b110;
        OutCSel = 2'd0; OutDSel = 2'd0; StackOp = 2'b00; ClrFlags = 1'b0;
        @(posedge Clock);
        #1;
        model_reset();

        // Reset state read
        cyc(1, 0, 4'hF, 3'b110, 3, 0, 0, 0, 'hFFFF, 0, 'hFFFF);

        // FunSel coverage on register 1
        cyc(1, 'h12F0, 4'b1101, 3'b010, 3, 1, 0, 0);
        cyc(1, 0,      4'b1101, 3'b001, 3, 1, 0, 0, -1, 'h12F0);
        cyc(1, 0,      4'b1101, 3'b000, 3, 1, 0, 0, -1, 'h12F1);
        cyc(1, 0,      4'b1101, 3'b000, 3, 1, 0, 0, -1, 'h12F0);
        cyc(1, 'hABCD, 4'b1101, 3'b100, 3, 1, 0, 0, -1, 'h12EF);
        cyc(1, 'h0077, 4'b1101, 3'b101, 3, 1, 0, 0, -1, 'h00CD);
        cyc(1, 0,      4'b1101, 3'b011, 3, 1, 0, 0, -1, 'h77CD);
        cyc(1, 0,      4'b1101, 3'b000, 3, 1, 0, 0, -1, 0);
        cyc(1, 0,      4'hF,    3'b110, 3, 1, 0, 0, -1, 'hFFFF);

        // Push three, pop three from reset
        cyc(0, 0, 4'hF, 3'b110, 3, 3, 0, 0);
        cyc(1, 0, 4'hF, 3'b110, 3, 3, 1, 0, -1, -1, 'hFFFE);
        cyc(1, 0, 4'hF, 3'b110, 3, 3, 1, 0, -1, -1, 'hFFFD);
        cyc(1, 0, 4'hF, 3'b110, 3, 3, 1, 0, -1, -1, 'hFFFC);
        cyc(1, 0, 4'hF, 3'b110, 3, 3, 2, 0, 'hFFFC, -1, 'hFFFC);
        cyc(1, 0, 4'hF, 3'b110, 3, 3, 2, 0, -1, -1, 'hFFFD);
        cyc(1, 0, 4'hF, 3'b110, 3, 3, 2, 0, -1, -1, 'hFFFE);
        cyc(1, 0, 4'hF, 3'b110, 3, 3, 0, 0, 'hFFFF);

        // Underflow, sticky hold, clear, set-beats-clear
        cyc(1, 0, 4'hF, 3'b110, 3, 3, 2, 0, -1, -1, 'hFFFF);
        for (int n = 0; n < 5; n++) cyc(1, 0, 4'hF, 3'b110, 3, 3, 0, 0);
        cyc(1, 0, 4'hF, 3'b110, 3, 3, 0, 1);
        cyc(1, 0, 4'hF, 3'b110, 3, 3, 0, 0);
        cyc(1, 0, 4'hF, 3'b110, 3, 3, 2, 1);
        cyc(1, 0, 4'hF, 3'b110, 3, 3, 0, 0);

        // Overflow and stack precedence over FunSel
        cyc(1, 0,      4'b0111, 3'b010, 3, 3, 0, 0);
        cyc(1, 0,      4'hF,    3'b110, 3, 3, 1, 0, 0, 0, 0);
        cyc(1, 'h5555, 4'b0110, 3'b010, 0, 3, 1, 0, -1, 0, 0);
        cyc(1, 0,      4'hF,    3'b110, 0, 3, 0, 0, 'h5555, 0, 0);

        // Reset overriding a push while Overflow is set
        cyc(0, 0, 4'hF, 3'b110, 3, 3, 1, 0);
        cyc(1, 0, 4'hF, 3'b110, 0, 3, 0, 0, -1, 'hFFFF);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 39) != 0), int'($urandom_range(0, 65535)),
                4'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0));
        end

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge Clock);
            waited++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: actual=%0d pending expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/address_register_bank.md
# address_register_bank

Parametrised address register bank: the successor to the fixed three-register PC/AR/SP file. It holds NREG address registers of WIDTH bits and provides two combinational read ports. It adds a hardware stack engine on one designated register (pre-decrement push / post-increment pop) with limit checking and sticky overflow/underflow flags. It sits between the ALU system's address bus and memory address mux, and is driven by the control unit's micro-op fields.

## Interface
- WIDTH, 16, register and data width; even, at least 4
- NREG, 4, number of address registers; at least 2
- SEL_W, $clog2(NREG), width of the read selects
- STEP, 1, increment/decrement amount for INC/DEC and stack ops
- SP_IDX, NREG-1, index of the register the stack engine acts on
- SP_LIMIT_LO, 0, lowest legal stack address
- SP_LIMIT_HI, 2**WIDTH-1, empty-stack SP value and the SP reset value
- Clock  input  1  the only clock; all state updates on its rising edge
- Reset  input  1  synchronous, active-low; sampled on the rising edge of Clock
- I  input  WIDTH  load data
- RegSel  input  NREG  per-register enable, active-low; bit k enables register k
- FunSel  input  3  register function
- OutCSel, OutDSel  input  SEL_W  read selects
- StackOp  input  2  00 none, 01 push, 10 pop, 11 reserved (treated as none)
- ClrFlags  input  1  clears Overflow and Underflow
- OutC, OutD  output  WIDTH  selected register contents
- OutS  output  WIDTH  memory address for the current stack op
- Overflow, Underflow  output  1  sticky stack-limit flags

## Operation
- FunSel codes apply to every register with its RegSel bit at 0:
  - 000: DEC, minus STEP
  - 001: INC, plus STEP
  - 010: LOAD I
  - 011: CLEAR
  - 100: load I[WIDTH/2-1:0] into the low half and zero the high half
  - 101: load I[WIDTH/2-1:0] into the high half and keep the low half
  - 110 and 111: hold
- INC/DEC wrap modulo 2^WIDTH for ordinary FunSel operations.
- Stack engine, active when StackOp is nonzero and legal, acting on register SP_IDX:
  - Push: OutS = SP-STEP; next SP = SP-STEP.
  - Pop: OutS = SP; next SP = SP+STEP.
  - No op: OutS = SP.
- Limit checks are evaluated in WIDTH+1 bits, with no wrap:
  - Push with SP < SP_LIMIT_LO+STEP: push suppressed, SP unchanged, Overflow set, OutS = SP.
  - Pop with SP+STEP > SP_LIMIT_HI: pop suppressed, SP unchanged, Underflow set, OutS = SP.
- Precedence: a nonzero StackOp (including a suppressed one) owns SP for that cycle, and FunSel/RegSel are ignored for SP_IDX only. Other enabled registers still execute FunSel.
- Flags: once set, a flag holds until ClrFlags=1 or Reset. If a set and ClrFlags occur in the same cycle, the set wins.
- Read ports: a select value of NREG or above returns 0. A read of a register updating in the same cycle returns the old value; there is no bypass.

## Timing
- Reset (Reset=0 at an edge):
  - All registers become 0, except SP_IDX, which becomes SP_LIMIT_HI.
  - Overflow and Underflow become 0.
  - Reset overrides FunSel, StackOp and ClrFlags in the same cycle. Asserting Reset mid-sequence discards any pending op.
- OutC, OutD and OutS are combinational from current state and inputs, with zero latency.
- Register updates and flag updates take effect one edge after the inputs are presented.
- Back-to-back stack ops are permitted every cycle; there is no handshake or stall.
- Flags become visible on the cycle after the offending op.

## Test plan
- Reset then read: drive Reset=0 for one edge, then OutCSel=3 and OutDSel=0 -> OutC=16'hFFFF, OutD=0, both flags 0.
- FunSel coverage on register 1 (RegSel=4'b1101):
  - LOAD 16'h12F0, then INC -> 16'h12F1.
  - Then DEC twice -> 16'h12EF.
  - Then code 100 with I=16'hABCD -> 16'h00CD.
  - Then code 101 with I=16'h0077 -> 16'h77CD.
  - CLEAR, then DEC -> 16'hFFFF (wrap).
- Push/pop: from reset, push three times -> OutS = FFFE, FFFD, FFFC on successive cycles, final SP=FFFC. Pop three times -> OutS = FFFC, FFFD, FFFE, final SP=FFFF.
- Underflow: pop at SP=FFFF -> SP stays FFFF and Underflow=1 next cycle. Underflow stays 1 for 5 idle cycles. ClrFlags pulse -> 0. ClrFlags together with a second bad pop -> Underflow stays 1.
- Overflow and precedence:
  - LOAD SP=0 via FunSel, then push -> SP stays 0 and Overflow=1.
  - In one cycle, push with FunSel=LOAD I=16'h5555 and RegSel=4'b0110 -> SP updates by the push only; register 0 loads 16'h5555.
  - In the same cycle, OutDSel=SP_IDX shows the pre-update SP.
- Reset mid-operation: assert Reset=0 in the same cycle as a push with ClrFlags=0 and Overflow=1 -> SP=FFFF and Overflow=0 next cycle. An out-of-range select (NREG=3 build, select 3) -> output 0.
